// File: rtl/hpm_event_collector.sv
// Converts per-cycle event occurrence counts into 1-bit-per-cycle increment pulses for hpm_counters.
// Each event has a saturating pending accumulator; dropped occurrences raise a sticky lost flag.
module hpm_event_collector #(
    parameter int unsigned HPM_NUM_EVENTS = 28,
    parameter int unsigned CNT_W          = 2,
    parameter int unsigned PEND_W         = 4
) (
    input  logic                             clk_i,
    input  logic                             rstn_i,
    input  logic [HPM_NUM_EVENTS*CNT_W-1:0]  event_cnt_i,
    input  logic                             clear_i,
    output logic [HPM_NUM_EVENTS:1]          events_o,
    output logic [HPM_NUM_EVENTS:1]          lost_o,
    output logic                             busy_o
);

    localparam logic [PEND_W:0] PendMax = (PEND_W + 1)'({PEND_W{1'b1}});

    logic [HPM_NUM_EVENTS:1] pend_nz;

    for (genvar e = 1; e <= HPM_NUM_EVENTS; e++) begin : g_evt
        logic [PEND_W-1:0] pend_q, pend_d;
        logic              events_q, events_d;
        logic              lost_q, lost_d;
        logic [PEND_W:0]   sum;
        logic [PEND_W:0]   rem;
        logic              emit;

        // One bit wider than the accumulator so pend + cnt never wraps.
        always_comb begin
            sum      = {1'b0, pend_q} + (PEND_W + 1)'(event_cnt_i[(e-1)*CNT_W +: CNT_W]);
            emit     = (sum != '0);
            rem      = sum - (PEND_W + 1)'(emit);
            pend_d   = rem[PEND_W-1:0];
            events_d = emit;
            lost_d   = lost_q;
            if (rem > PendMax) begin
                pend_d = '1;
                lost_d = 1'b1;
            end
            if (clear_i) begin
                pend_d   = '0;
                events_d = 1'b0;
                lost_d   = 1'b0;
            end
        end

        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                pend_q   <= '0;
                events_q <= 1'b0;
                lost_q   <= 1'b0;
            end else begin
                pend_q   <= pend_d;
                events_q <= events_d;
                lost_q   <= lost_d;
            end
        end

        assign events_o[e] = events_q;
        assign lost_o[e]   = lost_q;
        assign pend_nz[e]  = |pend_q;
    end

    assign busy_o = |pend_nz;

endmodule

// File: tb/tb_hpm_event_collector.sv
// Randomised and directed bench for hpm_event_collector against a per-event occurrence-count model.
module tb_hpm_event_collector;

    localparam int N      = 28;
    localparam int CW     = 2;
    localparam int PMAX   = 15;

    logic              clk_i = 1'b0;
    logic              rstn_i;
    logic [N*CW-1:0]   event_cnt_i;
    logic              clear_i;
    logic [N:1]        events_o;
    logic [N:1]        lost_o;
    logic              busy_o;

    int errors = 0;
    int checks = 0;

    hpm_event_collector #(
        .HPM_NUM_EVENTS (N),
        .CNT_W          (CW),
        .PEND_W         (4)
    ) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .event_cnt_i (event_cnt_i),
        .clear_i     (clear_i),
        .events_o    (events_o),
        .lost_o      (lost_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: outstanding occurrences per event as plain integers.
    int         m_pend [1:N];
    logic [N:1] m_ev;
    logic [N:1] m_lost;

    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int e = 1; e <= N; e++) m_pend[e] <= 0;
            m_ev   <= '0;
            m_lost <= '0;
        end else if (clear_i) begin
            for (int e = 1; e <= N; e++) m_pend[e] <= 0;
            m_ev   <= '0;
            m_lost <= '0;
        end else begin
            for (int e = 1; e <= N; e++) begin
                automatic int outstanding = m_pend[e] + int'(event_cnt_i[(e-1)*CW +: CW]);
                automatic int left;
                m_ev[e] <= (outstanding > 0);
                left = (outstanding > 0) ? outstanding - 1 : 0;
                if (left > PMAX) begin
                    m_pend[e] <= PMAX;
                    m_lost[e] <= 1'b1;
                end else begin
                    m_pend[e] <= left;
                end
            end
        end
    end

    function automatic logic model_busy();
        for (int e = 1; e <= N; e++) if (m_pend[e] != 0) return 1'b1;
        return 1'b0;
    endfunction

    always @(negedge clk_i) begin
        check("cyc_events", 32'(events_o), 32'(m_ev));
        check("cyc_lost", 32'(lost_o), 32'(m_lost));
        check("cyc_busy", 32'(busy_o), 32'(model_busy()));
    end

    task automatic set_cnt(input int e, input int v);
        automatic logic [1:0] v2 = v[1:0];
        event_cnt_i[(e-1)*CW +: CW] = v2;
    endtask

    logic [N:1] exp_vec;
    int         pulses;

    initial begin
        rstn_i      = 1'b0;
        clear_i     = 1'b0;
        event_cnt_i = '0;
        repeat (2) @(negedge clk_i);
        check("rst_events", 32'(events_o), 32'd0);
        check("rst_lost", 32'(lost_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        rstn_i = 1'b1;

        // Event 5: burst of 3 drains as 3 pulses, busy for 2 cycles.
        @(negedge clk_i);
        set_cnt(5, 3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            set_cnt(5, 0);
            check("burst5_ev", 32'(events_o[5]), (i < 3) ? 32'd1 : 32'd0);
            check("burst5_busy", 32'(busy_o), (i < 2) ? 32'd1 : 32'd0);
            check("burst5_lost", 32'(lost_o[5]), 32'd0);
        end

        // Event 2: steady 1/cycle gives contiguous pulses with nothing pending.
        set_cnt(2, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            if (i == 9) set_cnt(2, 0);
            check("steady2_ev", 32'(events_o[2]), 32'd1);
            check("steady2_busy", 32'(busy_o), 32'd0);
        end
        @(negedge clk_i);
        check("steady2_end", 32'(events_o[2]), 32'd0);

        // Event 1: 8 cycles of 3 saturates at 15 on the 8th; 8 + 15 pulses total.
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            set_cnt(1, (i < 8) ? 3 : 0);
            @(negedge clk_i);
            pulses += int'(events_o[1]);
            if (i == 6) check("sat1_lost_pre", 32'(lost_o[1]), 32'd0);
            if (i == 7) check("sat1_lost", 32'(lost_o[1]), 32'd1);
        end
        set_cnt(1, 0);
        check("sat1_pulses", 32'(pulses), 32'd23);
        check("sat1_sticky", 32'(lost_o[1]), 32'd1);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        check("clr_lost", 32'(lost_o), 32'd0);

        // Event 3: clear wins over a same-cycle input.
        set_cnt(3, 3);
        @(negedge clk_i);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        set_cnt(3, 0);
        check("clr3_ev", 32'(events_o[3]), 32'd0);
        check("clr3_busy", 32'(busy_o), 32'd0);
        check("clr3_lost", 32'(lost_o[3]), 32'd0);
        @(negedge clk_i);
        check("clr3_after", 32'(events_o[3]), 32'd0);

        // Event 4: reset in mid-drain clears outputs asynchronously.
        set_cnt(4, 3);
        repeat (2) @(negedge clk_i);
        set_cnt(4, 0);
        check("drain4_busy", 32'(busy_o), 32'd1);
        @(posedge clk_i);
        #2 rstn_i = 1'b0;
        #1;
        check("async_ev", 32'(events_o), 32'd0);
        check("async_busy", 32'(busy_o), 32'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("idle4_ev", 32'(events_o[4]), 32'd0);
            check("idle4_lost", 32'(lost_o[4]), 32'd0);
        end

        // All events at once, then edge slices alone.
        for (int e = 1; e <= N; e++) set_cnt(e, 1);
        @(negedge clk_i);
        event_cnt_i = '0;
        check("all_ev", 32'(events_o), 32'h0FFF_FFFF);
        set_cnt(1, 1);
        set_cnt(N, 1);
        @(negedge clk_i);
        event_cnt_i = '0;
        exp_vec = '0;
        exp_vec[1] = 1'b1;
        exp_vec[N] = 1'b1;
        check("edge_ev", 32'(events_o), 32'(exp_vec));
        check("edge_lit", 32'(events_o), 32'h0800_0001);

        // Random traffic with occasional clears; the per-cycle compare does the checking.
        for (int i = 0; i < 400; i++) begin
            for (int e = 1; e <= N; e++) set_cnt(e, int'($urandom_range(3, 0)));
            clear_i = ($urandom_range(39, 0) == 0);
            @(negedge clk_i);
        end
        clear_i     = 1'b0;
        event_cnt_i = '0;
        repeat (20) @(negedge clk_i);
        check("final_busy", 32'(busy_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
